// File: rtl/shared_bus_arb.sv
// Shared data bus with round-robin arbitration, bounded locking and a registered, zero-filled output.
// Optional even-parity output is enabled by defining SHARED_BUS_PARITY_EN.
module shared_bus_arb #(
  parameter int unsigned DATA_W   = 17,
  parameter int unsigned NUM_SRC  = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned NUM_MST  = 2,
  parameter int unsigned MST_W    = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MST-1:0]          req,
  input  logic [NUM_MST-1:0]          lock,
  input  logic [NUM_MST*SEL_W-1:0]    sel,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_en,
  output logic [NUM_MST-1:0]          gnt,
  output logic [DATA_W-1:0]           bus_out,
  output logic                        bus_vld,
  output logic [MST_W-1:0]            bus_owner,
`ifdef SHARED_BUS_PARITY_EN
  output logic                        bus_par,
`endif
  output logic                        sel_err
);

  localparam int unsigned NUM_SLOT = 2 ** SEL_W;
  localparam int unsigned NUM_OWN  = 2 ** MST_W;
  localparam int unsigned CNT_W    = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e             state;
  logic [MST_W-1:0]   last_owner;
  logic [CNT_W-1:0]   lock_cnt;

  // Slot and select tables padded to the full code space so every code decodes safely.
  logic [DATA_W-1:0]  slot_val [NUM_SLOT];
  logic [NUM_SLOT-1:0] slot_ok;
  logic [SEL_W-1:0]   sel_arr  [NUM_OWN];
  logic [NUM_OWN-1:0] req_pad;
  logic [NUM_OWN-1:0] lock_pad;

  for (genvar s = 0; s < NUM_SLOT; s++) begin : g_slot
    if (s < NUM_SRC) begin : g_impl
      assign slot_ok[s]  = src_en[s];
      assign slot_val[s] = src_en[s] ? src_data[s*DATA_W +: DATA_W] : '0;
    end else begin : g_none
      assign slot_ok[s]  = 1'b0;
      assign slot_val[s] = '0;
    end
  end

  for (genvar m = 0; m < NUM_OWN; m++) begin : g_mst
    if (m < NUM_MST) begin : g_impl
      assign sel_arr[m]  = sel[m*SEL_W +: SEL_W];
      assign req_pad[m]  = req[m];
      assign lock_pad[m] = lock[m];
    end else begin : g_none
      assign sel_arr[m]  = '0;
      assign req_pad[m]  = 1'b0;
      assign lock_pad[m] = 1'b0;
    end
  end

  logic               win_found;
  logic [MST_W-1:0]   win_idx;
  logic               stay;
  logic               grant_nxt;
  logic [MST_W-1:0]   owner_nxt;
  logic [SEL_W-1:0]   sel_nxt;
  logic [NUM_MST-1:0] gnt_nxt;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    // Scan upward from last_owner+1, then wrap to 0..last_owner.
    for (int m = 0; m < NUM_MST; m++) begin
      if (!win_found && req[m] && (m > int'(last_owner))) begin
        win_found = 1'b1;
        win_idx   = MST_W'(m);
      end
    end
    for (int m = 0; m < NUM_MST; m++) begin
      if (!win_found && req[m] && (m <= int'(last_owner))) begin
        win_found = 1'b1;
        win_idx   = MST_W'(m);
      end
    end
    stay      = (state == StOwned) && req_pad[bus_owner] && lock_pad[bus_owner] &&
                (lock_cnt < CNT_W'(LOCK_MAX));
    grant_nxt = stay || win_found;
    owner_nxt = stay ? bus_owner : win_idx;
    sel_nxt   = sel_arr[owner_nxt];
    gnt_nxt   = '0;
    for (int m = 0; m < NUM_MST; m++) begin
      gnt_nxt[m] = grant_nxt && (owner_nxt == MST_W'(m));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      last_owner <= MST_W'(NUM_MST - 1);
      lock_cnt   <= '0;
      gnt        <= '0;
      bus_out    <= '0;
      bus_vld    <= 1'b0;
      bus_owner  <= '0;
      sel_err    <= 1'b0;
`ifdef SHARED_BUS_PARITY_EN
      bus_par    <= 1'b0;
`endif
    end else if (grant_nxt) begin
      state      <= StOwned;
      last_owner <= owner_nxt;
      lock_cnt   <= stay ? (lock_cnt + CNT_W'(1)) : CNT_W'(1);
      gnt        <= gnt_nxt;
      bus_out    <= slot_val[sel_nxt];
      bus_vld    <= 1'b1;
      bus_owner  <= owner_nxt;
      sel_err    <= !slot_ok[sel_nxt];
`ifdef SHARED_BUS_PARITY_EN
      bus_par    <= ^slot_val[sel_nxt];
`endif
    end else begin
      state      <= StIdle;
      lock_cnt   <= '0;
      gnt        <= '0;
      bus_out    <= '0;
      bus_vld    <= 1'b0;
      bus_owner  <= '0;
      sel_err    <= 1'b0;
`ifdef SHARED_BUS_PARITY_EN
      bus_par    <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_shared_bus_arb.sv
// Randomised scoreboard bench for shared_bus_arb with a transaction-level arbitration model.
module tb_shared_bus_arb;

  localparam int DW = 17;
  localparam int NS = 14;
  localparam int SW = 4;
  localparam int NM = 2;
  localparam int MW = 1;
  localparam int LM = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n = 1'b0;
  logic [NM-1:0]     req   = '0;
  logic [NM-1:0]     lock  = '0;
  logic [NM*SW-1:0]  sel;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_en = '1;
  logic [NM-1:0]     gnt;
  logic [DW-1:0]     bus_out;
  logic              bus_vld;
  logic [MW-1:0]     bus_owner;
  logic              sel_err;
  logic              bus_par;

  logic [DW-1:0] srcs [NS];
  logic [SW-1:0] sels [NM];

  always_comb begin
    src_data = '0;
    for (int s = 0; s < NS; s++) src_data[s*DW +: DW] = srcs[s];
    sel = '0;
    for (int m = 0; m < NM; m++) sel[m*SW +: SW] = sels[m];
  end

  shared_bus_arb #(
    .DATA_W  (DW),
    .NUM_SRC (NS),
    .SEL_W   (SW),
    .NUM_MST (NM),
    .MST_W   (MW),
    .LOCK_MAX(LM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .lock     (lock),
    .sel      (sel),
    .src_data (src_data),
    .src_en   (src_en),
    .gnt      (gnt),
    .bus_out  (bus_out),
    .bus_vld  (bus_vld),
    .bus_owner(bus_owner),
`ifdef SHARED_BUS_PARITY_EN
    .bus_par  (bus_par),
`endif
    .sel_err  (sel_err)
  );

`ifndef SHARED_BUS_PARITY_EN
  assign bus_par = 1'b0;
`endif

  typedef struct {
    logic [NM-1:0] gnt;
    logic [DW-1:0] data;
    logic          vld;
    logic [MW-1:0] own;
    logic          err;
    logic          par;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner -1 means idle; run = consecutive cycles of current ownership.
  int m_owner = -1;
  int m_last  = NM - 1;
  int m_run   = 0;

  task automatic model_step();
    exp_t e;
    int   s;
    int   w;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = NM - 1;
      m_run   = 0;
    end else if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_run < LM) begin
      m_run++;
    end else begin
      w = -1;
      for (int k = 1; k <= NM; k++) begin
        if (w < 0 && req[(m_last + k) % NM]) w = (m_last + k) % NM;
      end
      m_owner = w;
      if (w >= 0) begin
        m_last = w;
        m_run  = 1;
      end
    end
    e.gnt = '0; e.data = '0; e.vld = 1'b0; e.own = '0; e.err = 1'b0; e.par = 1'b0;
    if (m_owner >= 0) begin
      e.gnt[m_owner] = 1'b1;
      e.vld = 1'b1;
      e.own = MW'(m_owner);
      s = int'(sels[m_owner]);
      if (s < NS && src_en[s]) e.data = srcs[s];
      else e.err = 1'b1;
      e.par = ^e.data;
    end
    expq.push_back(e);
  endtask

  // Inputs are set just after a negedge; the expectation for the coming posedge is queued.
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; lock = '0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      mon_e = expq.pop_front();
      check("gnt", 32'(gnt), 32'(mon_e.gnt));
      check("bus_out", 32'(bus_out), 32'(mon_e.data));
      check("bus_vld", 32'(bus_vld), 32'(mon_e.vld));
      check("bus_owner", 32'(bus_owner), 32'(mon_e.own));
      check("sel_err", 32'(sel_err), 32'(mon_e.err));
`ifdef SHARED_BUS_PARITY_EN
      check("bus_par", 32'(bus_par), 32'(mon_e.par));
`endif
    end
  end

  int run0;

  initial begin
    for (int s = 0; s < NS; s++) srcs[s] = '0;
    for (int m = 0; m < NM; m++) sels[m] = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_vld", 32'(bus_vld), 32'h0);
    rst_n = 1'b1;

    // Single master
    sels[0] = 4'd7; srcs[7] = 17'h003F5; req = 2'b01;
    step();
    check("single_out", 32'(bus_out), 32'h003F5);
    check("single_vld", 32'(bus_vld), 32'h1);
    check("single_owner", 32'(bus_owner), 32'h0);
    step();
    req = 2'b00;
    step();
    check("single_drop_vld", 32'(bus_vld), 32'h0);
    check("single_drop_out", 32'(bus_out), 32'h0);
    step();

    // Round-robin with no idle bubble
    do_reset();
    sels[0] = 4'd7; srcs[7] = 17'h00011; sels[1] = 4'd8; srcs[8] = 17'h00022;
    req = 2'b11; lock = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_out", 32'(bus_out), (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    req = 2'b00;
    step();

    // Lock limit: master 0 keeps the bus for exactly LOCK_MAX cycles
    do_reset();
    req = 2'b01; lock = 2'b01; run0 = 0;
    for (int i = 0; i < LM + 1; i++) begin
      if (i == 2) req = 2'b11;
      step();
      if (i < LM && gnt == 2'b01) run0++;
      if (i == LM) check("lock_handover", 32'(gnt), 32'h2);
    end
    check("lock_run", 32'(run0), 32'(LM));
    req = 2'b00; lock = 2'b00;
    step();

    // Bad select: out-of-range code, then disabled slot
    do_reset();
    srcs[3] = 17'h15555; req = 2'b01; sels[0] = 4'd15;
    step();
    check("badsel_hi_err", 32'(sel_err), 32'h1);
    check("badsel_hi_out", 32'(bus_out), 32'h0);
    sels[0] = 4'd3; src_en[3] = 1'b0;
    step();
    check("badsel_dis_err", 32'(sel_err), 32'h1);
    check("badsel_dis_vld", 32'(bus_vld), 32'h1);
    src_en = '1; req = 2'b00;
    step();

    // Asynchronous reset in the middle of an owned transfer
    sels[0] = 4'd5; srcs[5] = 17'h1ABCD; req = 2'b01;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_out", 32'(bus_out), 32'h0);
    check("midrst_vld", 32'(bus_vld), 32'h0);
    expq.delete();
    m_owner = -1; m_last = NM - 1; m_run = 0;
    step();
    rst_n = 1'b1;
    step();
    check("midrst_regrant", 32'(gnt), 32'h1);
    check("midrst_data", 32'(bus_out), 32'h1ABCD);
    req = 2'b00;
    step();

`ifdef SHARED_BUS_PARITY_EN
    sels[0] = 4'd7; srcs[7] = 17'h00007; req = 2'b01;
    step();
    check("par_odd", 32'(bus_par), 32'h1);
    srcs[7] = 17'h00003;
    step();
    check("par_even", 32'(bus_par), 32'h0);
    req = 2'b00;
    step();
`endif

    // Randomised traffic
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      for (int m = 0; m < NM; m++) begin
        req[m]  = ($urandom_range(0, 3) != 0);
        lock[m] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 2) == 0) sels[m] = SW'($urandom_range(0, 15));
      end
      for (int s = 0; s < NS; s++) srcs[s] = DW'($urandom);
      src_en = NS'($urandom) | NS'($urandom);
      step();
    end

    rst_n = 1'b1; req = '0; lock = '0;
    repeat (3) step();
    @(posedge clk);
    #2;
    check("queue_drained", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_bus_arb.md
Name: shared_bus_arb

Overview:
- Parametrised, registered successor of the single-core combinational data bus.
- Several bus masters (core controllers or a DMA engine) each request the shared bus with a source-select code.
- A round-robin arbiter with bounded locking grants one master. The granted master's selected source is driven onto a registered bus with zero-extension.
- Sits between the register file / AC / IR / memories and the ALU / memory write ports in the multi-core datapath.

Parameters:
- DATA_W, 17: bus width. Sources narrower than this are zero-extended externally (upper bits tied 0).
- NUM_SRC, 16: number of source slots. Slot index = select code.
- SEL_W, 4: select code width. Must satisfy 2^SEL_W >= NUM_SRC.
- NUM_MST, 2: number of masters. Range 1..8.
- MST_W, 1: owner index width. Equals clog2(NUM_MST), minimum 1.
- LOCK_MAX, 8: maximum consecutive granted cycles under lock before forced release. Must be >= 1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_MST  per-master bus request
- lock  in  NUM_MST  per-master request to keep ownership
- sel  in  NUM_MST*SEL_W  packed per-master select codes; master m uses bits [m*SEL_W +: SEL_W]
- src_data  in  NUM_SRC*DATA_W  packed sources; slot s uses bits [s*DATA_W +: DATA_W]
- src_en  in  NUM_SRC  slot implemented mask. A disabled slot reads as 0.
- gnt  out  NUM_MST  registered one-hot grant, or all-zero
- bus_out  out  DATA_W  registered bus value
- bus_vld  out  1  bus_out carries a granted transfer
- bus_owner  out  MST_W  index of the granted master; 0 when idle
- sel_err  out  1  one-cycle pulse: granted select code >= NUM_SRC or slot disabled

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - gnt = 0, bus_out = 0, bus_vld = 0, bus_owner = 0, sel_err = 0.
  - State = IDLE, last-owner pointer = NUM_MST-1 (so master 0 wins first), lock counter = 0.
- Reset asserted mid-transfer clears everything immediately. The first grant after release follows the normal 1-cycle latency.
- States are IDLE and OWNED.
- IDLE:
  - If any req: pick the first requesting master scanning upward from last_owner+1, with wrap-around.
  - Next edge: gnt = onehot(winner), bus_owner = winner, last_owner = winner, lock counter = 1, state = OWNED.
  - Otherwise stay IDLE.
- OWNED, owner o:
  - Stay while req[o] && lock[o] && counter < LOCK_MAX. Counter increments each cycle.
  - Otherwise re-arbitrate that same cycle, excluding nobody; the round-robin pointer has already moved past o.
  - If a winner exists, hand over with no idle bubble, counter = 1.
  - If no winner, go to IDLE: gnt = 0, bus_vld = 0.
- Lock limit: when counter reaches LOCK_MAX, the owner gets at most one more grant only if it is the sole requester. A competing requester always wins the next slot.
- Datapath, registered every cycle:
  - While a grant is registered for the next cycle: bus_out = src_data[slot sel[winner]] if sel < NUM_SRC and src_en[sel], else 0. bus_vld = 1.
  - Sources are re-sampled every owned cycle; the bus is not latched at grant time.
  - The owner may change sel while owning; the new value appears 1 cycle later.
  - Not granted: bus_out = 0, bus_vld = 0.
- Latency: req edge sampled at cycle t gives gnt/bus_vld/bus_out valid at t+1.
- sel_err: registered together with bus_out for the same transfer. Asserted for exactly each bad cycle; never when bus_vld = 0.
- Simultaneous req: round-robin order only, no fixed priority.
- req dropped while owning: release at the next edge, regardless of lock.
- Width rule: no arithmetic on data. Selection and zero-fill only.

Optional Feature:
- Macro: SHARED_BUS_PARITY_EN.
- Defined:
  - Extra output port bus_par (1 bit). Registered even parity (XOR reduction) of the bus_out value, in the same cycle as bus_out.
  - Reset value 0. Equals 0 whenever bus_vld = 0.
- Undefined: port bus_par and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset mid-grant:
  - Stimulus: master 0 owns with sel=5, src5=17'h1ABCD; assert rst_n low between edges.
  - Response: gnt, bus_out, bus_vld go to 0 immediately. After release with req[0] still high: gnt=01, bus_out=17'h1ABCD one cycle later.
- Single master:
  - Stimulus: req=01, sel0=7, src7=12'h3F5 zero-extended.
  - Response: next cycle gnt=01, bus_vld=1, bus_out=17'h003F5, bus_owner=0. Drop req: next cycle bus_vld=0, bus_out=0.
- Round-robin:
  - Stimulus: both masters request continuously, lock=0, sel0=7 (src=17'h00011), sel1=8 (src=17'h00022).
  - Response: gnt alternates 01, 10, 01, 10 and bus_out alternates 11, 22, with no idle cycle.
- Lock limit:
  - Stimulus: LOCK_MAX=8, master 0 req+lock held, master 1 requests from cycle 2.
  - Response: master 0 owns exactly 8 consecutive cycles, then gnt=10 on the 9th.
- Bad select:
  - Stimulus: NUM_SRC=14, sel0=15 for one cycle, then sel0=3 with src_en[3]=0.
  - Response: bus_vld=1, bus_out=0, and sel_err high for each of those 2 cycles.
- Parity (macro defined):
  - Stimulus: src=17'h00007.
  - Response: bus_par=1. With src=17'h00003: bus_par=0.
